// File: rtl/mem_arbiter_pkg.sv
// Shared widths, opcode constants and FSM encoding for the memory arbiter.
package mem_arbiter_pkg;

  localparam int SYS_ADDR_SPACE   = 32;
  localparam int INST_WIDTH       = 32;
  localparam int CACHE_DATA_WIDTH = 32;
  localparam int MEM_LAT_DEF      = 2;

  localparam logic       ON      = 1'b1;
  localparam logic       OFF     = 1'b0;
  localparam logic [2:0] LW_FUN3 = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  // Transaction captured at grant time and replayed onto the memory port.
  typedef struct packed {
    logic [SYS_ADDR_SPACE-1:0]   addr;
    logic                        we;
    logic [CACHE_DATA_WIDTH-1:0] wdata;
    logic [2:0]                  mode;
  } mem_txn_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single fixed-latency memory port.
// Data has priority until MAX_D_STREAK consecutive data grants starve a waiting
// fetch; then the fetch wins once. Each transaction is SERVE (MEM_LAT cycles)
// followed by a one-cycle DONE that pulses the ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT      = MEM_LAT_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // fetch port
  input  logic                        if_req_i,
  input  logic [SYS_ADDR_SPACE-1:0]   if_addr_i,
  input  logic                        if_flush_i,
  output logic                        if_ack_o,
  output logic [INST_WIDTH-1:0]       if_rdata_o,
  // data port
  input  logic                        d_req_i,
  input  logic                        d_we_i,
  input  logic [SYS_ADDR_SPACE-1:0]   d_addr_i,
  input  logic [CACHE_DATA_WIDTH-1:0] d_wdata_i,
  input  logic [2:0]                  d_mode_i,
  output logic                        d_ack_o,
  output logic [CACHE_DATA_WIDTH-1:0] d_rdata_o,
  // memory port
  output logic                        mem_re_o,
  output logic                        mem_we_o,
  output logic [SYS_ADDR_SPACE-1:0]   mem_addr_o,
  output logic [CACHE_DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]                  mem_mode_o,
  input  logic [CACHE_DATA_WIDTH-1:0] mem_rdata_i,
  output logic                        busy_o
);

  localparam int                SW       = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]     STRK_MAX = SW'(MAX_D_STREAK);
  localparam logic [3:0]        CNT_LOAD = 4'(MEM_LAT - 1);

  arb_state_e                  state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [SW-1:0]               streak_q, streak_d;
  mem_txn_t                    txn_q, txn_d;
  logic                        gnt_d_q, gnt_d_d;   // 1: current txn belongs to data port
  logic                        flush_q, flush_d;   // fetch flushed earlier in this txn
  logic [INST_WIDTH-1:0]       if_pend_q, if_pend_d;
  logic [INST_WIDTH-1:0]       if_rdata_q, if_rdata_d;
  logic [CACHE_DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic serve, last_serve, if_done_ok;

  assign serve      = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign last_serve = serve && (cnt_q == 4'd0);
  // A flush seen in this very DONE cycle also kills the ack, so it is
  // combined with the registered flag rather than waiting a cycle.
  assign if_done_ok = (state_q == DONE) && !gnt_d_q && !flush_q && !if_flush_i;

  // Next-state, grant, streak and read-data capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    txn_d      = txn_q;
    gnt_d_d    = gnt_d_q;
    flush_d    = flush_q;
    if_pend_d  = if_pend_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (!if_req_i) streak_d = '0;
        if (d_req_i && (streak_q < STRK_MAX || !if_req_i)) begin
          state_d = SERVE_D;
          gnt_d_d = ON;
          txn_d   = '{addr: d_addr_i, we: d_we_i, wdata: d_wdata_i, mode: d_mode_i};
          cnt_d   = CNT_LOAD;
          flush_d = OFF;
          if (if_req_i && streak_q < STRK_MAX) streak_d = streak_q + 1'b1;
        end else if (if_req_i) begin
          state_d  = SERVE_I;
          gnt_d_d  = OFF;
          txn_d    = '{addr: if_addr_i, we: OFF, wdata: '0, mode: LW_FUN3};
          cnt_d    = CNT_LOAD;
          flush_d  = OFF;
          streak_d = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (state_q == SERVE_I && if_flush_i) flush_d = ON;
        if (last_serve) begin
          state_d = DONE;
          if (gnt_d_q) d_rdata_d = mem_rdata_i;
          else         if_pend_d = INST_WIDTH'(mem_rdata_i);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (if_done_ok) if_rdata_d = if_pend_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      txn_q      <= '0;
      gnt_d_q    <= OFF;
      flush_q    <= OFF;
      if_pend_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      txn_q      <= txn_d;
      gnt_d_q    <= gnt_d_d;
      flush_q    <= flush_d;
      if_pend_q  <= if_pend_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_re_o    = serve && !txn_q.we;
  assign mem_we_o    = serve &&  txn_q.we;
  assign mem_addr_o  = serve ? txn_q.addr  : '0;
  assign mem_wdata_o = serve ? txn_q.wdata : '0;
  assign mem_mode_o  = serve ? txn_q.mode  : 3'b000;

  assign if_ack_o   = if_done_ok;
  assign d_ack_o    = (state_q == DONE) && gnt_d_q;
  // The fetched word becomes visible together with its ack.
  assign if_rdata_o = if_done_ok ? if_pend_q : if_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a transaction-timeline model.
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam int MAXS = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_flush_i, d_req_i, d_we_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [2:0]  d_mode_i;

  logic        if_ack_o, d_ack_o, mem_re_o, mem_we_o, busy_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic [2:0]  mem_mode_o;

  logic        a1_if_ack, a1_d_ack, a1_re, a1_we, a1_busy;
  logic [31:0] a1_if_rdata, a1_d_rdata, a1_addr, a1_wdata;
  logic [2:0]  a1_mode;
  logic        a15_if_ack, a15_d_ack, a15_re, a15_we, a15_busy;
  logic [31:0] a15_if_rdata, a15_d_rdata, a15_addr, a15_wdata;
  logic [2:0]  a15_mode;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.MEM_LAT(LAT), .MAX_D_STREAK(MAXS)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_mode_i(d_mode_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_mode_o(mem_mode_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o));

  mem_arbiter #(.MEM_LAT(1), .MAX_D_STREAK(MAXS)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_ack_o(a1_if_ack), .if_rdata_o(a1_if_rdata),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_mode_i(d_mode_i), .d_ack_o(a1_d_ack), .d_rdata_o(a1_d_rdata),
    .mem_re_o(a1_re), .mem_we_o(a1_we), .mem_addr_o(a1_addr),
    .mem_wdata_o(a1_wdata), .mem_mode_o(a1_mode), .mem_rdata_i(mem_rdata_i),
    .busy_o(a1_busy));

  mem_arbiter #(.MEM_LAT(15), .MAX_D_STREAK(MAXS)) u_dut15 (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_ack_o(a15_if_ack), .if_rdata_o(a15_if_rdata),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_mode_i(d_mode_i), .d_ack_o(a15_d_ack), .d_rdata_o(a15_d_rdata),
    .mem_re_o(a15_re), .mem_we_o(a15_we), .mem_addr_o(a15_addr),
    .mem_wdata_o(a15_wdata), .mem_mode_o(a15_mode), .mem_rdata_i(mem_rdata_i),
    .busy_o(a15_busy));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: m_p is the position on the transaction timeline
  // (0 = arbitration cycle, 1..LAT = memory access, LAT+1 = ack cycle).
  int          m_p, m_streak;
  bit          m_isd, m_we, m_fl;
  logic [31:0] m_addr, m_wdata, m_ifr, m_ifpend, m_dr;
  logic [2:0]  m_mode;

  // Directed-test recorders.
  int f_if, f_d, f1_if, f15_if, re_cnt, we_cnt;
  bit seq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_streak = 0; m_fl = 0; m_isd = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_mode = '0;
    m_ifr = '0; m_ifpend = '0; m_dr = '0;
  endtask

  task automatic clr_rec();
    f_if = -1; f_d = -1; f1_if = -1; f15_if = -1; re_cnt = 0; we_cnt = 0;
    seq.delete();
  endtask

  task automatic compare();
    bit serve, done, ifok;
    serve = (m_p >= 1) && (m_p <= LAT);
    done  = (m_p == LAT + 1);
    ifok  = done && !m_isd && !m_fl && !if_flush_i;
    chk("busy",     32'(busy_o),   32'(m_p != 0));
    chk("mem_re",   32'(mem_re_o), 32'(serve && !m_we));
    chk("mem_we",   32'(mem_we_o), 32'(serve && m_we));
    chk("mem_addr", mem_addr_o,    serve ? m_addr : 32'h0);
    chk("mem_wdata", mem_wdata_o,  serve ? m_wdata : 32'h0);
    chk("mem_mode", 32'(mem_mode_o), serve ? 32'(m_mode) : 32'h0);
    chk("if_ack",   32'(if_ack_o), 32'(ifok));
    chk("d_ack",    32'(d_ack_o),  32'(done && m_isd));
    chk("if_rdata", if_rdata_o,    ifok ? m_ifpend : m_ifr);
    chk("d_rdata",  d_rdata_o,     m_dr);
    chk("ack_excl", 32'(if_ack_o && d_ack_o), 32'h0);
  endtask

  task automatic model_step();
    bit pick_d, pick_i;
    if (m_p == 0) begin
      pick_d = d_req_i && (m_streak < MAXS || !if_req_i);
      pick_i = !pick_d && if_req_i;
      if (!if_req_i)   m_streak = 0;
      else if (pick_d) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
      else if (pick_i) m_streak = 0;
      if (pick_d) begin
        m_isd = 1; m_we = d_we_i; m_addr = d_addr_i; m_wdata = d_wdata_i; m_mode = d_mode_i;
      end else if (pick_i) begin
        m_isd = 0; m_we = 0; m_addr = if_addr_i; m_wdata = 0; m_mode = 3'b010;
      end
      if (pick_d || pick_i) begin m_p = 1; m_fl = 0; end
    end else if (m_p <= LAT) begin
      if (!m_isd && if_flush_i) m_fl = 1;
      if (m_p == LAT) begin
        if (m_isd) m_dr = mem_rdata_i;
        else       m_ifpend = mem_rdata_i;
      end
      m_p++;
    end else begin
      if (!m_isd && !m_fl && !if_flush_i) m_ifr = m_ifpend;
      m_p = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    compare();
    if (if_ack_o) begin if (f_if < 0) f_if = cyc; seq.push_back(1'b0); end
    if (d_ack_o)  begin if (f_d < 0)  f_d  = cyc; seq.push_back(1'b1); end
    if (a1_if_ack  && f1_if  < 0) f1_if  = cyc;
    if (a15_if_ack && f15_if < 0) f15_if = cyc;
    if (mem_re_o) re_cnt++;
    if (mem_we_o) we_cnt++;
    model_step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_flush_i = 0; d_req_i = 0; d_we_i = 0;
    if_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; d_mode_i = 0;
  endtask

  task automatic wait_idle();
    int n;
    idle_inputs();
    n = 0;
    tick();
    while (m_p != 0 && n < 40) begin tick(); n++; end
    if (m_p != 0) begin
      bad++; total++;
      $display("FAIL wait_idle: timeout waiting for idle, got busy want idle");
    end
  endtask

  initial begin
    bit pat[6];
    idle_inputs();
    mem_rdata_i = 32'h0000_0013;
    rst_i = 0;
    model_reset();
    clr_rec();
    repeat (2) @(posedge clk_i);
    #1;
    // Reset state.
    chk("rst_busy",   32'(busy_o),   32'h0);
    chk("rst_mem_re", 32'(mem_re_o), 32'h0);
    chk("rst_ifr",    if_rdata_o,    32'h0);
    chk("rst_dr",     d_rdata_o,     32'h0);
    rst_i = 1;

    // Single fetch, plus latency on MEM_LAT=1 and MEM_LAT=15 instances.
    cyc = 0;
    if_req_i = 1; if_addr_i = 32'h100;
    tick();
    if_req_i = 0;
    repeat (19) tick();
    chk("fetch_ack_cyc",   f_if,   3);
    chk("fetch_re_cnt",    re_cnt, 2);
    chk("fetch_rdata",     if_rdata_o, 32'h0000_0013);
    chk("lat1_ack_cyc",    f1_if,  2);
    chk("lat15_ack_cyc",   f15_if, 16);

    // Flushed fetch: no ack, rdata holds, bubble back to idle.
    wait_idle(); clr_rec(); cyc = 0;
    mem_rdata_i = 32'h0000_0055;
    if_req_i = 1; if_addr_i = 32'h104;
    tick();
    if_req_i = 0;
    tick();
    if_flush_i = 1;
    tick();
    if_flush_i = 0;
    tick();
    chk("flush_busy4", 32'(busy_o), 32'h0);
    repeat (3) tick();
    chk("flush_no_ack", f_if, -1);
    chk("flush_rdata",  if_rdata_o, 32'h0000_0013);

    // Simultaneous store + fetch: data first.
    wait_idle(); clr_rec(); cyc = 0;
    if_req_i = 1; if_addr_i = 32'h108;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'hDEADBEEF; d_mode_i = 3'b010;
    tick();
    d_req_i = 0;
    repeat (5) tick();
    if_req_i = 0;
    repeat (5) tick();
    chk("both_d_ack_cyc",  f_d,    3);
    chk("both_if_ack_cyc", f_if,   7);
    chk("both_we_cnt",     we_cnt, 2);
    chk("both_re_cnt",     re_cnt, 2);

    // Data streak limit.
    wait_idle(); clr_rec(); cyc = 0;
    if_req_i = 1; if_addr_i = 32'h10C;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h300; d_mode_i = 3'b000;
    repeat (26) tick();
    idle_inputs();
    if (seq.size() >= 6) begin
      for (int i = 0; i < 6; i++) pat[i] = seq[i];
      chk("streak_seq", {26'h0, pat[0], pat[1], pat[2], pat[3], pat[4], pat[5]}, 32'b111101);
    end else begin
      chk("streak_nacks", seq.size(), 6);
    end

    // Asynchronous reset during the first access cycle of a store.
    wait_idle(); clr_rec(); cyc = 0;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h400; d_wdata_i = 32'h1234_5678; d_mode_i = 3'b010;
    tick();
    d_req_i = 0;
    rst_i = 0;
    #1;
    chk("arst_busy",   32'(busy_o),   32'h0);
    chk("arst_we",     32'(mem_we_o), 32'h0);
    chk("arst_addr",   mem_addr_o,    32'h0);
    chk("arst_ifr",    if_rdata_o,    32'h0);
    chk("arst_dr",     d_rdata_o,     32'h0);
    model_reset();
    #1;
    rst_i = 1;
    clr_rec();
    repeat (8) tick();
    chk("arst_no_ack", f_d, -1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if_req_i    = ($urandom_range(0, 1) == 1);
      d_req_i     = ($urandom_range(0, 1) == 1);
      d_we_i      = ($urandom_range(0, 1) == 1);
      if_flush_i  = ($urandom_range(0, 15) == 0);
      if_addr_i   = $urandom;
      d_addr_i    = $urandom;
      d_wdata_i   = $urandom;
      d_mode_i    = 3'($urandom_range(0, 7));
      mem_rdata_i = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning memory access cycles per transaction (legal range 1..15).
REQ-002 SHALL have parameter MAX_D_STREAK, default 4, meaning consecutive data grants allowed while a fetch waits.
REQ-003 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have fetch ports: if_req_i in 1 request; if_addr_i in `SYS_ADDR_SPACE fetch address; if_flush_i in 1 discard in-flight fetch; if_ack_o out 1 completion pulse; if_rdata_o out `INST_WIDTH instruction.
REQ-006 SHALL have data ports: d_req_i in 1; d_we_i in 1 store when high; d_addr_i in `SYS_ADDR_SPACE; d_wdata_i in `CACHE_DATA_WIDTH; d_mode_i in 3 funct3 size/sign; d_ack_o out 1; d_rdata_o out `CACHE_DATA_WIDTH.
REQ-007 SHALL have memory ports: mem_re_o out 1; mem_we_o out 1; mem_addr_o out `SYS_ADDR_SPACE; mem_wdata_o out `CACHE_DATA_WIDTH; mem_mode_o out 3; mem_rdata_i in `CACHE_DATA_WIDTH.
REQ-008 SHALL have busy_o out 1, high in any state other than IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, DONE.
REQ-010 IDLE: d_req_i high and streak < MAX_D_STREAK -> SERVE_D; else if_req_i high -> SERVE_I; else d_req_i high -> SERVE_D; else stay.
REQ-011 On entering SERVE_x SHALL latch address, we, wdata, mode of the granted requester; later input changes ignored until DONE.
REQ-012 SERVE_x SHALL last exactly MEM_LAT cycles via down-counter loaded with MEM_LAT-1; SHALL then go to DONE.
REQ-013 During SERVE_x: mem_addr_o/mem_mode_o/mem_wdata_o driven from latched values; mem_re_o = !latched_we; mem_we_o = latched_we; SERVE_I forces mode = `LW_FUN3, we = 0.
REQ-014 Outside SERVE_x all mem_* outputs SHALL be 0.
REQ-015 Last SERVE cycle SHALL register mem_rdata_i into the granted port's rdata register; the other port's rdata holds.
REQ-016 DONE SHALL last one cycle, pulse granted ack for that cycle, then return to IDLE; req-to-ack latency = MEM_LAT+1 cycles, one idle bubble between transactions.
REQ-017 if_rdata_o/d_rdata_o SHALL hold last captured value until next capture for that port.
REQ-018 Streak counter SHALL increment on each SERVE_D grant while if_req_i high, clear on SERVE_I grant or when if_req_i low in IDLE, saturate at MAX_D_STREAK.
REQ-019 if_flush_i high in any cycle of SERVE_I or DONE-after-SERVE_I SHALL suppress that if_ack_o and leave if_rdata_o unchanged; memory access still completes.
REQ-020 if_flush_i SHALL have no effect on data transactions; stores never abort.
REQ-021 Requester dropping req mid-transaction SHALL not abort it; ack still pulses.
REQ-022 Requester holding req through its ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-023 if_ack_o and d_ack_o SHALL never be high in the same cycle.

Reset
REQ-024 rst_i low SHALL immediately force IDLE, counter 0, streak 0, all outputs 0 including rdata registers, independent of clk_i.
REQ-025 Reset mid-transaction SHALL discard it with no ack after release.
REQ-026 First grant possible at first rising edge after rst_i deasserts.

Structure
REQ-027 FSM state encodings, MEM_LAT default and width macros SHALL live in the shared defines header beside `SYS_ADDR_SPACE, `On/`Off, `LW_FUN3.
REQ-028 Single flat module; no sub-module; memory instance lives in the parent.

Verification (MEM_LAT=2, MAX_D_STREAK=4)
REQ-029 if_req_i=1, if_addr_i=0x100, mem_rdata_i=0x00000013 -> mem_re_o high cycles 1-2, if_ack_o at cycle 3, if_rdata_o=0x00000013.
REQ-030 if_req_i and d_req_i (store 0xDEADBEEF to 0x200, mode SW) same cycle -> SERVE_D first, mem_we_o high 2 cycles, d_ack_o cycle 3, fetch ack cycle 7.
REQ-031 d_req_i held continuously with if_req_i high -> exactly 4 data acks, then one fetch ack, then data resumes.
REQ-032 if_flush_i pulsed in cycle 2 of fetch -> no if_ack_o, if_rdata_o unchanged, busy_o low at cycle 4.
REQ-033 rst_i low during SERVE_D cycle 1 -> all outputs 0 asynchronously, no d_ack_o after release.
REQ-034 MEM_LAT=1 fetch -> ack at cycle 2; MEM_LAT=15 -> ack at cycle 16.
